rv32_mtimer: RTL and testbench
==============================

# rv32_mtimer

Memory-mapped machine timer that sits on the core's data-memory bus (`dmem_*`) and drives the core's `irq_i`. It holds a free-running 64-bit `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a sticky pending flag. The interrupt is raised when `mtime` crosses `mtimecmp`. The top level muxes `dmem_rdata` from this block whenever `hit_o` is high.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0000_0200: byte base of the register window. It is 32-byte aligned and sits just above the 128-word data RAM.

Ports:
- `clk` input 1: single clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `addr_i` input 32: byte address, connected to `dmem_addr`.
- `wdata_i` input 32: write data, connected to `dmem_wdata`.
- `we_i` input 1: write strobe, connected to `dmem_we`.
- `rdata_o` output 32: combinational read data. It is 0 when there is no hit.
- `hit_o` output 1: combinational; high when `addr_i[31:5] == BASE_ADDR[31:5]` and the offset is below 0x1C.
- `irq_o` output 1: interrupt request, connected to `irq_i`. It is `pending & ctrl.irq_en`, both of which are flops.

## Operation
Register map. Offsets are byte offsets. Only full-word accesses are supported; `addr_i[1:0]` is ignored.
- 0x00 MTIME_LO: read/write.
- 0x04 MTIME_HI: read/write.
- 0x08 MTIMECMP_LO: read/write.
- 0x0C MTIMECMP_HI: read/write.
- 0x10 CTRL: bit0 `en`, bit1 `irq_en`, bits[15:8] `div`; other bits read 0.
- 0x14 STATUS: bit0 `pending`. Writing 1 to bit0 clears it; writing 0 has no effect.
- 0x18 PERIOD: reload increment; see Configuration.

Writes take effect at the clock edge where `we_i & hit_o` is high.

Prescaler:
- An 8-bit counter `pcnt` increments each cycle while `en` is set.
- `tick` is asserted when `pcnt == div`; on that cycle `pcnt` returns to 0.
- `div = 0` gives a tick every cycle. A `div` of N gives one tick every N+1 cycles.
- Clearing `en` resets `pcnt` to 0 and stops `mtime`.

Counter:
- On each `tick`, `mtime <= mtime + 1`, as a full 64-bit increment with carry from LO into HI.
- The counter wraps from 2^64−1 to 0.
- A software write to MTIME_LO or MTIME_HI in the same cycle as a tick wins. The written half takes the written value and the other half holds; no increment is applied that cycle.

Compare:
- `match = (mtime >= mtimecmp)`, an unsigned 64-bit comparison on the registered values.
- `match_q` is `match` delayed by one flop.
- `pending` is set on a rising edge of match, i.e. `match & ~match_q`.
- A W1C write and a set in the same cycle: set wins.
- While `match` stays high after a clear, `pending` is not set again. It re-arms only after `match` falls, e.g. when software raises `mtimecmp` or `mtime` wraps.

Reset values:
- `mtime` = 0.
- `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
- CTRL = 0.
- `pending` = 0.
- `match_q` = 1, which suppresses a spurious edge right after reset.
- `pcnt` = 0.
- PERIOD = 0.
- `irq_o` = 0.

Reset may be asserted at any time, including mid-count. All state returns to the reset values asynchronously.

## Timing
- Read is combinational with zero latency, matching the RAM behaviour on the core's load path.
- Write lands at the same clock edge.
- Interrupt latency:
  - Edge k: `mtime` first becomes ≥ `mtimecmp`.
  - Edge k+1: `pending` is set and `irq_o` rises (if `irq_en` is set).
- `irq_o` falls in the cycle after the edge at which STATUS W1C or `irq_en = 0` is written.
- When `irq_en` is enabled while `pending` is already 1, `irq_o` rises in the following cycle.

## Configuration
`RV32_MTIMER_AUTORELOAD_EN`:
- **Defined:** PERIOD is implemented. On the cycle `pending` is set, if PERIOD ≠ 0, `mtimecmp <= mtimecmp + PERIOD` (64-bit add, PERIOD zero-extended). If software writes `mtimecmp` in that same cycle, the software write wins.
- **Undefined:** offset 0x18 reads 0, writes to it are ignored, and no reload logic is present. Offset 0x18 still hits.

## Structure
- Add to `rv32_pkg`:
  - the register offset localparams `MTIMER_OFF_*`;
  - a packed struct `mtimer_ctrl_t` with fields `en`, `irq_en`, `div`.
- Sub-module `rv32_mtimer_prescaler`, with ports `clk`, `rst_n`, `en`, `div[7:0]` and output `tick`.
- All register, compare and bus decode logic lives in the top module.

## Test plan
1. **Reset:** release `rst_n` and read all offsets. Expect MTIME = 0, MTIMECMP_LO/HI = 0xFFFFFFFF, CTRL = 0, STATUS = 0, `irq_o` = 0.
2. **Match with interrupt masked:** write MTIMECMP_HI = 0, then MTIMECMP_LO = 10, then CTRL = 0x1. Expect STATUS = 1 one edge after `mtime` reaches 10, with `irq_o` still 0. Then write CTRL = 0x3; expect `irq_o` = 1 on the next cycle.
3. **Prescaler:** write CTRL = 0x0301 (div = 3). Expect `mtime` = 10 after 40 cycles, and MTIME_LO to advance once per 4 cycles.
4. **Carry:** write MTIME_LO = 0xFFFFFFFF, then CTRL = 0x1. On the next tick expect MTIME_HI = 1 and MTIME_LO = 0. Then write MTIME_LO on a tick cycle and expect the written value with no increment.
5. **W1C while matched:** with `mtime` ≥ `mtimecmp`, write STATUS = 1. Expect `pending` = 0 and no re-set. Raise MTIMECMP_LO above `mtime` and let the counter reach it; expect `pending` = 1 again.
6. **Autoreload:** with the macro defined, PERIOD = 5, MTIMECMP = 5, CTRL = 0x3. Expect `pending` when `mtime` = 5 and MTIMECMP_LO = 10 on the next edge. With the macro undefined, a read of 0x18 returns 0 after writing 5.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared definitions for the rv32 machine timer: register offsets and the CTRL layout.
// No logic; pure types, constants and a read-back packing helper.
// Imported by the timer top and its interface users.
package rv32_pkg;

    localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
    localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
    localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;
    localparam logic [4:0] MTIMER_OFF_STATUS      = 5'h14;
    localparam logic [4:0] MTIMER_OFF_PERIOD      = 5'h18;
    // First offset past the register window; addresses at or above it do not hit.
    localparam logic [4:0] MTIMER_OFF_END         = 5'h1C;

    typedef struct packed {
        logic [7:0] div;
        logic       irq_en;
        logic       en;
    } mtimer_ctrl_t;

    // CTRL as seen on the bus: en in bit0, irq_en in bit1, div in bits[15:8].
    function automatic logic [31:0] mtimer_ctrl_pack(mtimer_ctrl_t c);
        return {16'h0000, c.div, 6'b000000, c.irq_en, c.en};
    endfunction

endpackage

// File: rtl/rv32_mtimer_if.sv
// Data-memory bus slice seen by the machine timer (address, write data, strobe, read-back).
// Purely combinational wiring; no latency of its own.
// No backpressure: every access completes in the cycle it is presented.
interface rv32_mtimer_if;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        we_i;
    logic [31:0] rdata_o;
    logic        hit_o;

    modport master (output addr_i, output wdata_i, output we_i, input rdata_o, input hit_o);
    modport slave  (input addr_i, input wdata_i, input we_i, output rdata_o, output hit_o);
endinterface

// File: rtl/rv32_mtimer_prescaler.sv
// Prescaler for the machine timer: one tick every div+1 enabled cycles.
// Tick is combinational from the registered count (zero latency).
// No backpressure; clearing en parks the counter at 0.
module rv32_mtimer_prescaler (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] div,
    output logic       tick
);

    logic [7:0] pcnt_q;
    logic [7:0] pcnt_d;

    assign tick = en && (pcnt_q == div);

    // Next count: hold at 0 while disabled, wrap to 0 on the tick cycle.
    always_comb begin
        pcnt_d = pcnt_q;
        if (!en) begin
            pcnt_d = 8'd0;
        end else if (tick) begin
            pcnt_d = 8'd0;
        end else begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= 8'd0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/rv32_mtimer.sv
// Machine timer on the dmem bus: 64-bit mtime/mtimecmp, prescaler, sticky pending, irq_o.
// Reads are combinational (zero latency); writes land at the edge; irq one edge after match.
// No backpressure. Optional RV32_MTIMER_AUTORELOAD_EN adds the PERIOD reload of mtimecmp.
module rv32_mtimer
    import rv32_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0200
) (
    input  logic           clk,
    input  logic           rst_n,
    rv32_mtimer_if.slave   bus,
    output logic           irq_o
);

    logic [4:0]   off;
    logic         hit;
    logic         wr;
    logic         wr_mtime_lo;
    logic         wr_mtime_hi;
    logic         wr_cmp_lo;
    logic         wr_cmp_hi;
    logic         wr_ctrl;
    logic         wr_status;

    logic [63:0]  mtime_q;
    logic [63:0]  mtime_d;
    logic [63:0]  mtimecmp_q;
    logic [63:0]  mtimecmp_d;
    mtimer_ctrl_t ctrl_q;
    mtimer_ctrl_t ctrl_d;
    logic         pending_q;
    logic         pending_d;
    logic         match;
    logic         match_q;
    logic         pend_set;
    logic         tick;
    logic [31:0]  rdata;
    logic         unused_addr;

`ifdef RV32_MTIMER_AUTORELOAD_EN
    logic         wr_period;
    logic [31:0]  period_q;
`endif

    // Byte lanes are ignored: only full-word accesses exist.
    assign off         = {bus.addr_i[4:2], 2'b00};
    assign unused_addr = ^bus.addr_i[1:0];
    assign hit         = (bus.addr_i[31:5] == BASE_ADDR[31:5]) && (off < MTIMER_OFF_END);
    assign wr          = bus.we_i && hit;

    assign wr_mtime_lo = wr && (off == MTIMER_OFF_MTIME_LO);
    assign wr_mtime_hi = wr && (off == MTIMER_OFF_MTIME_HI);
    assign wr_cmp_lo   = wr && (off == MTIMER_OFF_MTIMECMP_LO);
    assign wr_cmp_hi   = wr && (off == MTIMER_OFF_MTIMECMP_HI);
    assign wr_ctrl     = wr && (off == MTIMER_OFF_CTRL);
    assign wr_status   = wr && (off == MTIMER_OFF_STATUS);
`ifdef RV32_MTIMER_AUTORELOAD_EN
    assign wr_period   = wr && (off == MTIMER_OFF_PERIOD);
`endif

    rv32_mtimer_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (ctrl_q.en),
        .div   (ctrl_q.div),
        .tick  (tick)
    );

    // Compare on registered values; a pending set is a rising edge of match.
    assign match    = (mtime_q >= mtimecmp_q);
    assign pend_set = match && !match_q;
    assign irq_o    = pending_q && ctrl_q.irq_en;

    // mtime next state: a software write to either half beats the tick increment.
    always_comb begin
        mtime_d = mtime_q;
        if (wr_mtime_lo) begin
            mtime_d[31:0] = bus.wdata_i;
        end else if (wr_mtime_hi) begin
            mtime_d[63:32] = bus.wdata_i;
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // mtimecmp next state: software write first, then optional periodic reload.
    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (wr_cmp_lo) begin
            mtimecmp_d[31:0] = bus.wdata_i;
        end else if (wr_cmp_hi) begin
            mtimecmp_d[63:32] = bus.wdata_i;
`ifdef RV32_MTIMER_AUTORELOAD_EN
        end else if (pend_set && (period_q != 32'd0)) begin
            mtimecmp_d = mtimecmp_q + {32'd0, period_q};
`endif
        end
    end

    // CTRL and STATUS next state; a new match edge beats a same-cycle W1C.
    always_comb begin
        ctrl_d    = ctrl_q;
        pending_d = pending_q && !(wr_status && bus.wdata_i[0]);
        if (wr_ctrl) begin
            ctrl_d.en     = bus.wdata_i[0];
            ctrl_d.irq_en = bus.wdata_i[1];
            ctrl_d.div    = bus.wdata_i[15:8];
        end
        if (pend_set) begin
            pending_d = 1'b1;
        end
    end

    // State registers; match_q resets high so reset itself never looks like a match edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            ctrl_q     <= '0;
            pending_q  <= 1'b0;
            match_q    <= 1'b1;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            ctrl_q     <= ctrl_d;
            pending_q  <= pending_d;
            match_q    <= match;
        end
    end

`ifdef RV32_MTIMER_AUTORELOAD_EN
    // PERIOD register, only present when auto-reload is built in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= 32'd0;
        end else if (wr_period) begin
            period_q <= bus.wdata_i;
        end
    end
`endif

    // Read mux; zero whenever the address misses the window.
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (off)
                MTIMER_OFF_MTIME_LO:    rdata = mtime_q[31:0];
                MTIMER_OFF_MTIME_HI:    rdata = mtime_q[63:32];
                MTIMER_OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
                MTIMER_OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
                MTIMER_OFF_CTRL:        rdata = mtimer_ctrl_pack(ctrl_q);
                MTIMER_OFF_STATUS:      rdata = {31'd0, pending_q};
`ifdef RV32_MTIMER_AUTORELOAD_EN
                MTIMER_OFF_PERIOD:      rdata = period_q;
`endif
                default:                rdata = 32'd0;
            endcase
        end
    end

    assign bus.rdata_o = rdata;
    assign bus.hit_o   = hit;

endmodule

// File: tb/tb_rv32_mtimer.sv
// Bench for rv32_mtimer: directed scenarios plus randomized bus traffic against a reference model.
// The model advances once per clock edge from the same bus inputs the DUT sees.
// Outputs are sampled on the falling edge; inputs change 1 time unit after the rising edge.
module tb_rv32_mtimer;

    localparam logic [31:0] BASE = 32'h0000_0200;

    logic clk;
    logic rst_n;
    logic irq_o;

    rv32_mtimer_if bus ();

    rv32_mtimer #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .irq_o (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state, kept at register-map level.
    logic [63:0] m_mtime;
    logic [63:0] m_cmp;
    logic        m_en;
    logic        m_irq_en;
    logic [7:0]  m_div;
    logic        m_pend;
    logic        m_prev_match;
    logic [31:0] m_period;
    int          m_age;       // enabled cycles elapsed since en last went high
    logic [31:0] last_rd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mtime      = 64'd0;
        m_cmp        = 64'hFFFF_FFFF_FFFF_FFFF;
        m_en         = 1'b0;
        m_irq_en     = 1'b0;
        m_div        = 8'd0;
        m_pend       = 1'b0;
        m_prev_match = 1'b1;
        m_period     = 32'd0;
        m_age        = 0;
    endtask

    function automatic logic exp_hit(input logic [31:0] a);
        return ((a >> 5) == (BASE >> 5)) && ((a & 32'h1F) < 32'h1C);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (exp_hit(a)) begin
            case (a & 32'h1C)
                32'h00: v = m_mtime[31:0];
                32'h04: v = m_mtime[63:32];
                32'h08: v = m_cmp[31:0];
                32'h0C: v = m_cmp[63:32];
                32'h10: v = {16'd0, m_div, 6'd0, m_irq_en, m_en};
                32'h14: v = {31'd0, m_pend};
`ifdef RV32_MTIMER_AUTORELOAD_EN
                32'h18: v = m_period;
`endif
                default: v = 32'd0;
            endcase
        end
        return v;
    endfunction

    // One clock edge of the reference model, using the values held before the edge.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d, input logic w);
        logic        wr;
        logic [31:0] o;
        logic        tick;
        logic        match;
        logic        rise;
        logic        en_old;
        wr     = w && exp_hit(a);
        o      = a & 32'h1C;
        tick   = m_en && ((m_age % (int'(m_div) + 1)) == int'(m_div));
        match  = (m_mtime >= m_cmp);
        rise   = match && !m_prev_match;
        m_prev_match = match;
        if (wr && o == 32'h00)      m_mtime[31:0]  = d;
        else if (wr && o == 32'h04) m_mtime[63:32] = d;
        else if (tick)              m_mtime        = m_mtime + 64'd1;
        if (wr && o == 32'h08)      m_cmp[31:0]    = d;
        else if (wr && o == 32'h0C) m_cmp[63:32]   = d;
`ifdef RV32_MTIMER_AUTORELOAD_EN
        else if (rise && m_period != 32'd0) m_cmp = m_cmp + {32'd0, m_period};
        if (wr && o == 32'h18)      m_period = d;
`endif
        m_pend = rise || (m_pend && !(wr && o == 32'h14 && d[0]));
        en_old = m_en;
        if (wr && o == 32'h10) begin
            m_en     = d[0];
            m_irq_en = d[1];
            m_div    = d[15:8];
        end
        m_age = (en_old && m_en) ? m_age + 1 : 0;
    endtask

    // One bus cycle: present, check outputs at the falling edge, advance the model at the rising edge.
    task automatic bus_cycle(input logic [31:0] a, input logic [31:0] d, input logic w);
        bus.addr_i  = a;
        bus.wdata_i = d;
        bus.we_i    = w;
        @(negedge clk);
        last_rd = bus.rdata_o;
        chk($sformatf("hit@%h", a), bus.hit_o, exp_hit(a));
        chk($sformatf("rdata@%h", a), bus.rdata_o, exp_rdata(a));
        chk("irq", irq_o, m_pend && m_irq_en);
        @(posedge clk);
        model_step(a, d, w);
        #1;
    endtask

    task automatic wr32(input logic [4:0] off, input logic [31:0] d);
        bus_cycle(BASE + 32'(off), d, 1'b1);
    endtask

    task automatic rd32(input logic [4:0] off);
        bus_cycle(BASE + 32'(off), 32'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) rd32(5'h00);
    endtask

    task automatic rand_op();
        int          r;
        logic [31:0] d;
        logic [4:0]  off;
        logic        ne;
        r = int'($urandom_range(0, 99));
        if (r < 60) begin
            bus_cycle(BASE + 32'($urandom_range(0, 6) * 4) + 32'($urandom_range(0, 3)), $urandom, 1'b0);
        end else if (r < 64) begin
            bus_cycle(BASE + 32'h1C + 32'($urandom_range(0, 3)), $urandom, r[0]);
        end else if (r < 67) begin
            bus_cycle($urandom, $urandom, r[0]);
        end else begin
            off = 5'($urandom_range(0, 6) * 4);
            d   = $urandom;
            case (off)
                5'h00: d = (r < 70) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                    : m_mtime[31:0] + 32'($urandom_range(0, 8));
                5'h04: d = r[0] ? 32'hFFFF_FFFF : 32'd0;
                5'h08: d = m_mtime[31:0] + 32'($urandom_range(0, 40));
                5'h0C: d = m_mtime[63:32] + 32'(r[1:0] == 2'b11);
                5'h10: begin
                    ne = ($urandom_range(0, 9) < 8);
                    d[0] = ne;
                    d[1] = r[0];
                    // Keep div fixed while the prescaler keeps running.
                    d[15:8] = (m_en && ne) ? m_div : 8'($urandom_range(0, 3));
                end
                5'h14: d = {$urandom, r[0]};
                default: d = 32'($urandom_range(0, 8));
            endcase
            wr32(off, d);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.addr_i  = 32'd0;
        bus.wdata_i = 32'd0;
        bus.we_i    = 1'b0;
        last_rd     = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset values.
        rd32(5'h00); chk("rst_mtime_lo", last_rd, 32'd0);
        rd32(5'h04); chk("rst_mtime_hi", last_rd, 32'd0);
        rd32(5'h08); chk("rst_cmp_lo", last_rd, 32'hFFFF_FFFF);
        rd32(5'h0C); chk("rst_cmp_hi", last_rd, 32'hFFFF_FFFF);
        rd32(5'h10); chk("rst_ctrl", last_rd, 32'd0);
        rd32(5'h14); chk("rst_status", last_rd, 32'd0);
        chk("rst_irq", irq_o, 1'b0);
        bus_cycle(BASE + 32'h1C, 32'd0, 1'b0); chk("miss_rdata", last_rd, 32'd0);

        // Match with the interrupt masked, then unmask.
        wr32(5'h0C, 32'd0);
        wr32(5'h08, 32'd10);
        wr32(5'h10, 32'h1);
        idle(12);
        rd32(5'h14); chk("masked_pending", last_rd, 32'd1);
        chk("masked_irq", irq_o, 1'b0);
        wr32(5'h10, 32'h3);
        rd32(5'h14); chk("unmask_irq", irq_o, 1'b1);

        // W1C while still matched: stays clear, re-arms after cmp is raised.
        wr32(5'h14, 32'h1);
        idle(5);
        rd32(5'h14); chk("w1c_stays_clear", last_rd, 32'd0);
        chk("w1c_irq", irq_o, 1'b0);
        wr32(5'h08, m_mtime[31:0] + 32'd8);
        idle(12);
        rd32(5'h14); chk("rearm_pending", last_rd, 32'd1);
        wr32(5'h14, 32'h1);

        // Prescaler div=3: ten increments in forty cycles.
        wr32(5'h10, 32'h0);
        wr32(5'h00, 32'd0);
        wr32(5'h04, 32'd0);
        wr32(5'h10, 32'h0301);
        idle(40);
        rd32(5'h00); chk("presc_mtime", last_rd, 32'd10);

        // Carry from LO into HI, then a write on a tick cycle wins.
        wr32(5'h10, 32'h0);
        wr32(5'h04, 32'd0);
        wr32(5'h00, 32'hFFFF_FFFF);
        wr32(5'h10, 32'h0101);
        rd32(5'h00); chk("carry_pre_lo", last_rd, 32'hFFFF_FFFF);
        rd32(5'h04); chk("carry_pre_hi", last_rd, 32'd0);
        rd32(5'h04); chk("carry_hi", last_rd, 32'd1);
        rd32(5'h00); chk("carry_lo", last_rd, 32'd0);
        idle(1);
        wr32(5'h00, 32'h0000_1234);
        rd32(5'h00); chk("tick_write_wins", last_rd, 32'h0000_1234);

        // Periodic reload (or an inert PERIOD slot without the option).
        wr32(5'h10, 32'h0);
        wr32(5'h0C, 32'd0);
        wr32(5'h08, 32'd5);
        wr32(5'h04, 32'd0);
        wr32(5'h00, 32'd0);
        wr32(5'h18, 32'd5);
        wr32(5'h14, 32'h1);
        wr32(5'h10, 32'h3);
        idle(6);
        rd32(5'h14); chk("reload_pending", last_rd, 32'd1);
`ifdef RV32_MTIMER_AUTORELOAD_EN
        rd32(5'h08); chk("reload_cmp_lo", last_rd, 32'd10);
`else
        rd32(5'h18); chk("period_reads_zero", last_rd, 32'd0);
        rd32(5'h08); chk("no_reload_cmp_lo", last_rd, 32'd5);
`endif

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) rand_op();

        // Asynchronous reset in the middle of a count.
        wr32(5'h10, 32'h3);
        idle(5);
        bus.addr_i = BASE + 32'h0;
        bus.we_i   = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_mtime", bus.rdata_o, 32'd0);
        chk("arst_irq", irq_o, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd32(5'h08); chk("arst_cmp_lo", last_rd, 32'hFFFF_FFFF);

        for (int i = 0; i < 1500; i++) rand_op();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
